// File: rtl/hourglass_pkg.sv
// Shared entry type and ordering rule for the hourglass sorter.
// HOURGLASS_DESCENDING_EN selects descending key order; ties always favour the lower index.
package hourglass_pkg;

   localparam int unsigned KEY_WIDTH = 8;
   localparam int unsigned IDXW      = 5;

   typedef struct packed {
      logic                 vld;
      logic [KEY_WIDTH-1:0] key;
      logic [IDXW-1:0]      idx;
   } entry_t;

   // True when a must be passed upward in preference to b.
   function automatic logic wins(entry_t a, entry_t b);
      if (a.vld != b.vld) return a.vld;
      if (a.key != b.key) begin
`ifdef HOURGLASS_DESCENDING_EN
         return a.key > b.key;
`else
         return a.key < b.key;
`endif
      end
      return a.idx <= b.idx;
   endfunction

   function automatic int unsigned level_cnt(int unsigned n, int unsigned l);
      return (n + (32'd1 << l) - 32'd1) >> l;
   endfunction

   // Offset of level l inside the flattened tree array.
   function automatic int unsigned level_base(int unsigned n, int unsigned l);
      int unsigned sum;
      sum = 0;
      for (int unsigned k = 0; k < l; k++) sum += level_cnt(n, k);
      return sum;
   endfunction

endpackage

// File: rtl/hourglass_node.sv
// Two-input compare/select cell of the selection tree; a_i comes from the lower-index side.
module hourglass_node
   import hourglass_pkg::*;
(
   input  entry_t a_i,
   input  entry_t b_i,
   output entry_t y_o
);

   assign y_o = wins(a_i, b_i) ? a_i : b_i;

endmodule

// File: rtl/hourglass_sorter.sv
// Stable key sorter: parallel load of N keys, streamed out one per beat in key order.
// Build option HOURGLASS_DESCENDING_EN (see hourglass_pkg) reverses the key order.
module hourglass_sorter #(
   parameter int unsigned NUMBER_OF_ELEMENTS = 24,
   parameter int unsigned KEY_WIDTH          = 8,
   parameter int unsigned OUTPUT_INDEX_WIDTH = 5
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   load,
   input  logic [NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0] in_keys,
   output logic [KEY_WIDTH-1:0]                   axis_out_key,
   output logic [OUTPUT_INDEX_WIDTH-1:0]          axis_out_index,
   output logic                                   axis_out_valid,
   input  logic                                   axis_out_ready
);
   import hourglass_pkg::entry_t;
   import hourglass_pkg::IDXW;
   import hourglass_pkg::level_cnt;
   import hourglass_pkg::level_base;

   localparam int unsigned N      = NUMBER_OF_ELEMENTS;
   localparam int unsigned Levels = $clog2(N);
   localparam int unsigned Total  = level_base(N, Levels + 1);

   if (N < 2) begin : g_chk_n
      $error("NUMBER_OF_ELEMENTS must be at least 2");
   end
   if (OUTPUT_INDEX_WIDTH < $clog2(N)) begin : g_chk_idx
      $error("OUTPUT_INDEX_WIDTH too small for NUMBER_OF_ELEMENTS");
   end
   if (OUTPUT_INDEX_WIDTH != IDXW || KEY_WIDTH != hourglass_pkg::KEY_WIDTH) begin : g_chk_pkg
      $error("widths must match hourglass_pkg");
   end

   logic [N-1:0]         vld_q, vld_d, clr;
   logic [KEY_WIDTH-1:0] key_q [N];
   logic [KEY_WIDTH-1:0] key_d [N];
   entry_t               tree  [Total];
   entry_t               root;
   logic                 take;

   // Leaves carry their slot number as the implicit original index.
   for (genvar i = 0; i < N; i++) begin : g_leaf
      assign tree[i] = '{vld: vld_q[i], key: key_q[i], idx: IDXW'(i)};
   end

   for (genvar l = 1; l <= Levels; l++) begin : g_lvl
      for (genvar j = 0; j < level_cnt(N, l); j++) begin : g_pos
         localparam int unsigned Src = level_base(N, l - 1) + 2 * j;
         localparam int unsigned Dst = level_base(N, l) + j;
         if (2 * j + 1 < level_cnt(N, l - 1)) begin : g_node
            hourglass_node u_node (
               .a_i (tree[Src]),
               .b_i (tree[Src+1]),
               .y_o (tree[Dst])
            );
         end else begin : g_fwd
            assign tree[Dst] = tree[Src];
         end
      end
   end

   assign root = tree[Total-1];
   assign take = root.vld & axis_out_ready;

   // Load wins over a same-cycle handshake: the retiring beat is simply overwritten.
   always_comb begin
      clr = '0;
      for (int i = 0; i < N; i++) begin
         if (take && root.idx == IDXW'(i)) clr[i] = 1'b1;
      end
      vld_d = vld_q & ~clr;
      key_d = key_q;
      if (load) begin
         vld_d = '1;
         for (int i = 0; i < N; i++) key_d[i] = in_keys[i*KEY_WIDTH +: KEY_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < N; i++) key_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         key_q <= key_d;
      end
   end

   assign axis_out_valid = root.vld;
   assign axis_out_key   = root.vld ? root.key : '0;
   assign axis_out_index = root.vld ? root.idx : '0;

endmodule

// File: tb/tb_hourglass_sorter.sv
// Scoreboard bench for hourglass_sorter; expectations come from a counting-sort model.
module tb_hourglass_sorter;
   localparam int N  = 24;
   localparam int KW = 8;
   localparam int IW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              load;
   logic [N*KW-1:0]   in_keys;
   logic [KW-1:0]     axis_out_key;
   logic [IW-1:0]     axis_out_index;
   logic              axis_out_valid;
   logic              axis_out_ready;

   typedef struct {
      int key;
      int idx;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    keys  [N];
   bit    rand_rdy = 1'b0;

   hourglass_sorter #(
      .NUMBER_OF_ELEMENTS (N),
      .KEY_WIDTH          (KW),
      .OUTPUT_INDEX_WIDTH (IW)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .load           (load),
      .in_keys        (in_keys),
      .axis_out_key   (axis_out_key),
      .axis_out_index (axis_out_index),
      .axis_out_valid (axis_out_valid),
      .axis_out_ready (axis_out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Stable order falls out of scanning key values first, then indices ascending.
   function automatic void push_expected();
      beat_t b;
      for (int s = 0; s < 256; s++) begin
         int v;
`ifdef HOURGLASS_DESCENDING_EN
         v = 255 - s;
`else
         v = s;
`endif
         for (int i = 0; i < N; i++) begin
            if (keys[i] == v) begin
               b.key = v;
               b.idx = i;
               exp_q.push_back(b);
            end
         end
      end
   endfunction

   task automatic do_load();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) in_keys[i*KW +: KW] = keys[i][KW-1:0];
      load = 1'b1;
      exp_q.delete();
      push_expected();
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, "_valid_after"}, axis_out_valid, 0);
   endtask

   initial begin
      axis_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         axis_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: retire beats against the scoreboard and hold outputs stable across stalls.
   initial begin
      logic          st;
      logic [KW-1:0] pk;
      logic [IW-1:0] pi;
      st = 1'b0;
      pk = '0;
      pi = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            st = 1'b0;
            continue;
         end
         if (st) begin
            check("stall_valid", axis_out_valid, 1);
            check("stall_key", axis_out_key, pk);
            check("stall_idx", axis_out_index, pi);
         end
         if (axis_out_valid && axis_out_ready && !load) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               check("beat_key", axis_out_key, b.key);
               check("beat_idx", axis_out_index, b.idx);
            end
         end
         st = axis_out_valid && !axis_out_ready && !load;
         pk = axis_out_key;
         pi = axis_out_index;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      rst     = 1'b1;
      load    = 1'b0;
      in_keys = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      repeat (10) begin
         @(negedge clk);
         check("rst_valid", axis_out_valid, 0);
         check("rst_key", axis_out_key, 0);
         check("rst_idx", axis_out_index, 0);
      end

      for (int i = 0; i < N; i++) keys[i] = 23 - i;
      do_load();
      check("first_beat_latency", axis_out_valid, 1);
      drain("reverse");

      for (int i = 0; i < N; i++) keys[i] = 3;
      do_load();
      drain("equal");

      rand_rdy = 1'b1;
      for (int i = 0; i < N; i++) keys[i] = $urandom_range(0, 3);
      do_load();
      drain("random_ties");
      rand_rdy = 1'b0;

      for (int i = 0; i < N; i++) keys[i] = $urandom_range(0, 255);
      do_load();
      n = 0;
      while (exp_q.size() > 19 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("five_taken", exp_q.size(), 19);
      for (int i = 0; i < N; i++) keys[i] = $urandom_range(0, 255);
      do_load();
      drain("reload");

      for (int i = 0; i < N; i++) keys[i] = (i % 2 == 0) ? 255 : 0;
      do_load();
      drain("alternating");

      for (int i = 0; i < N; i++) keys[i] = $urandom_range(0, 255);
      do_load();
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_valid", axis_out_valid, 0);
      check("midrst_key", axis_out_key, 0);
      check("midrst_idx", axis_out_index, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_valid", axis_out_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
